// File: rtl/myo_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : myo_sched_pkg
//  Description : Shared types and helpers for the myocontrol SPI scheduler.
//                Holds the sequencer state encoding, the index-width helper
//                and the upper bound on slave selects.
//  Revision    : 1.0 - initial release
// ============================================================================
package myo_sched_pkg;

  localparam int MAX_MOTORS = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } sched_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/myo_sched_next_index.sv
`default_nettype none
// ============================================================================
//  Module      : myo_sched_next_index
//  Description : Combinational find-first-set over a motor mask, searching
//                strictly above cur_idx, or from cur_idx upward when
//                include_cur is set (used to pick the first motor of a sweep).
//  Revision    : 1.0 - initial release
// ============================================================================
module myo_sched_next_index #(
  parameter int NUM_MOTORS = 9,
  parameter int IDX_W      = 4
) (
  input  logic [NUM_MOTORS-1:0] mask,
  input  logic [IDX_W-1:0]      cur_idx,
  input  logic                  include_cur,
  output logic                  found,
  output logic [IDX_W-1:0]      next_idx
);

  // Scan from the top down so the lowest qualifying bit is the last written.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur_idx)) || (include_cur && (i == int'(cur_idx))))) begin
        found    = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/myo_spi_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : myo_spi_scheduler
//  Description : Periodic round-robin slave-select sequencer for one
//                myocontrol SPI master. Each period it walks the enabled
//                motors in ascending order: select, lead, start pulse, wait
//                for completion (with timeout), deselect, gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module myo_spi_scheduler
  import myo_sched_pkg::*;
#(
  parameter  int NUM_MOTORS     = 9,
  parameter  int PERIOD_CYCLES  = 50000,
  parameter  int SS_LEAD        = 4,
  parameter  int SS_GAP         = 8,
  parameter  int TIMEOUT_CYCLES = 2048,
  localparam int IDX_W          = clog2_min1(NUM_MOTORS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_MOTORS-1:0] motor_mask,
  input  logic                  power_sense_n,
  input  logic                  err_clear,
  input  logic                  spi_done,
  output logic                  spi_start,
  output logic [IDX_W-1:0]      motor_sel,
  output logic [NUM_MOTORS-1:0] ss_n_o,
  output logic                  busy,
  output logic                  cycle_done,
  output logic                  overrun,
  output logic [NUM_MOTORS-1:0] timeout_mask,
  output logic [31:0]           sweep_count
);

  // One shared phase counter serves LEAD, WAIT_DONE and GAP.
  localparam int CNT_MAX = (SS_LEAD > SS_GAP)
                         ? ((SS_LEAD > TIMEOUT_CYCLES) ? SS_LEAD : TIMEOUT_CYCLES)
                         : ((SS_GAP  > TIMEOUT_CYCLES) ? SS_GAP  : TIMEOUT_CYCLES);
  localparam int CNT_W   = clog2_min1(CNT_MAX);
  localparam int TMR_W   = clog2_min1(PERIOD_CYCLES);

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_MOTORS-1:0] mask_q, mask_d;
  logic [NUM_MOTORS-1:0] ss_n_q, ss_n_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic                  spi_start_q, spi_start_d;
  logic                  busy_q, busy_d;
  logic                  cycle_done_q, cycle_done_d;
  logic                  overrun_q, overrun_d;
  logic [NUM_MOTORS-1:0] tmask_q, tmask_d;
  logic [31:0]           sweep_count_q, sweep_count_d;

  logic                  tick;
  logic                  first_found, next_found;
  logic [IDX_W-1:0]      first_idx, next_idx;

  // Lowest enabled motor in the live mask, for sweep start.
  myo_sched_next_index #(
    .NUM_MOTORS (NUM_MOTORS),
    .IDX_W      (IDX_W)
  ) u_first (
    .mask        (motor_mask),
    .cur_idx     ('0),
    .include_cur (1'b1),
    .found       (first_found),
    .next_idx    (first_idx)
  );

  // Next enabled motor above the current one in the latched mask.
  myo_sched_next_index #(
    .NUM_MOTORS (NUM_MOTORS),
    .IDX_W      (IDX_W)
  ) u_next (
    .mask        (mask_q),
    .cur_idx     (idx_q),
    .include_cur (1'b0),
    .found       (next_found),
    .next_idx    (next_idx)
  );

  assign tick = (timer_q == TMR_W'(PERIOD_CYCLES - 1));

  // Period timer, sequencer next state and all registered outputs.
  always_comb begin
    timer_d       = enable ? (tick ? '0 : timer_q + TMR_W'(1)) : '0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    mask_d        = mask_q;
    ss_n_d        = ss_n_q;
    sel_d         = sel_q;
    spi_start_d   = 1'b0;
    cycle_done_d  = 1'b0;
    sweep_count_d = sweep_count_q;
    overrun_d     = tick && (state_q != IDLE);
    tmask_d       = err_clear ? '0 : tmask_q;

    case (state_q)
      IDLE: begin
        // first_found already implies a non-zero mask; other ticks are dropped.
        if (tick && enable && !power_sense_n && first_found) begin
          mask_d  = motor_mask;
          idx_d   = first_idx;
          sel_d   = first_idx;
          ss_n_d  = ~(NUM_MOTORS'(1) << first_idx);
          cnt_d   = '0;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (cnt_q == CNT_W'(SS_LEAD - 1)) begin
          cnt_d       = '0;
          spi_start_d = 1'b1;
          state_d     = START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A real completion takes priority over a coincident timeout.
        if (spi_done) begin
          ss_n_d  = '1;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmask_d[idx_q] = 1'b1;
          ss_n_d         = '1;
          cnt_d          = '0;
          state_d        = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(SS_GAP - 1)) begin
          cnt_d = '0;
          if (!enable || power_sense_n) begin
            state_d = IDLE;
          end else if (next_found) begin
            idx_d   = next_idx;
            sel_d   = next_idx;
            ss_n_d  = ~(NUM_MOTORS'(1) << next_idx);
            state_d = LEAD;
          end else begin
            cycle_done_d  = 1'b1;
            sweep_count_d = sweep_count_q + 32'd1;
            state_d       = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        ss_n_d  = '1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Single register stage for FSM state, counters and outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      timer_q       <= '0;
      idx_q         <= '0;
      mask_q        <= '0;
      ss_n_q        <= '1;
      sel_q         <= '0;
      spi_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      cycle_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      tmask_q       <= '0;
      sweep_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      mask_q        <= mask_d;
      ss_n_q        <= ss_n_d;
      sel_q         <= sel_d;
      spi_start_q   <= spi_start_d;
      busy_q        <= busy_d;
      cycle_done_q  <= cycle_done_d;
      overrun_q     <= overrun_d;
      tmask_q       <= tmask_d;
      sweep_count_q <= sweep_count_d;
    end
  end

  assign spi_start    = spi_start_q;
  assign motor_sel    = sel_q;
  assign ss_n_o       = ss_n_q;
  assign busy         = busy_q;
  assign cycle_done   = cycle_done_q;
  assign overrun      = overrun_q;
  assign timeout_mask = tmask_q;
  assign sweep_count  = sweep_count_q;

endmodule
`default_nettype wire

// File: tb/tb_myo_spi_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_myo_spi_scheduler
//  Description : Directed self-checking bench for myo_spi_scheduler with a
//                queue of expected motor indices and a simple SPI responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_myo_spi_scheduler;

  localparam int NM       = 4;
  localparam int PER      = 100;
  localparam int LEAD     = 2;
  localparam int GAP      = 3;
  localparam int TO       = 50;
  localparam int DONE_LAT = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [NM-1:0] motor_mask = '0;
  logic          power_sense_n = 1'b0;
  logic          err_clear = 1'b0;
  logic          spi_done = 1'b0;
  logic          spi_start, busy, cycle_done, overrun;
  logic [1:0]    motor_sel;
  logic [NM-1:0] ss_n_o, timeout_mask;
  logic [31:0]   sweep_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel_cyc = 0, high_cyc = 0, start_cyc = 0;
  int done_at = -1;
  int cd_count = 0, ov_count = 0;
  int mon_m;
  bit gap_valid = 1'b0;
  logic [NM-1:0] prev_ss = '1;
  logic [NM-1:0] withhold = '0;
  logic [NM-1:0] mon_exp_ss;
  int exp_q[$];

  myo_spi_scheduler #(
    .NUM_MOTORS     (NM),
    .PERIOD_CYCLES  (PER),
    .SS_LEAD        (LEAD),
    .SS_GAP         (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .motor_mask    (motor_mask),
    .power_sense_n (power_sense_n),
    .err_clear     (err_clear),
    .spi_done      (spi_done),
    .spi_start     (spi_start),
    .motor_sel     (motor_sel),
    .ss_n_o        (ss_n_o),
    .busy          (busy),
    .cycle_done    (cycle_done),
    .overrun       (overrun),
    .timeout_mask  (timeout_mask),
    .sweep_count   (sweep_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SPI master model: completion DONE_LAT cycles after each start unless withheld.
  always @(negedge clock) begin
    spi_done = (cyc == done_at);
    if (spi_start && !reset && !withhold[motor_sel]) done_at = cyc + DONE_LAT;
  end

  // Output monitor: pops the expected motor on every start pulse.
  always @(negedge clock) begin
    if (!reset) begin
      chk("ss_one_low", ($countones(~ss_n_o) <= 1), 1);
      if (prev_ss == 4'hF && ss_n_o != 4'hF) begin
        if (gap_valid) chk("gap_len", cyc - high_cyc, GAP);
        sel_cyc = cyc;
      end
      if (prev_ss != 4'hF && ss_n_o == 4'hF && busy) begin
        high_cyc  = cyc;
        gap_valid = 1'b1;
      end
      if (cycle_done) begin
        cd_count++;
        chk("cd_after_gap", cyc - high_cyc, GAP);
      end
      if (overrun) ov_count++;
      if (spi_start) begin
        start_cyc = cyc;
        chk("lead_len", cyc - sel_cyc, LEAD);
        chk("start_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_m      = exp_q.pop_front();
          mon_exp_ss = ~(4'b0001 << mon_m);
          chk("motor_sel", motor_sel, mon_m);
          chk("ss_at_start", ss_n_o, mon_exp_ss);
        end
      end
      if (!busy) gap_valid = 1'b0;
    end
    prev_ss = ss_n_o;
  end

  task automatic start_sweep();
    int c0;
    int n;
    @(negedge clock);
    c0     = cyc;
    enable = 1'b1;
    n      = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!busy && n < 300);
    chk("start_latency", cyc - c0, PER);
  endtask

  task automatic wait_cd(input int bound);
    int n = 0;
    while (!cycle_done && n < bound) begin
      @(negedge clock);
      n++;
    end
    chk("cycle_done_seen", cycle_done, 1);
    chk("idle_at_cd", busy, 0);
  endtask

  task automatic wait_start(input logic [1:0] m);
    int n = 0;
    while (!(spi_start && motor_sel == m) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("start_seen", spi_start, 1);
  endtask

  task automatic pulse_err_clear();
    @(negedge clock);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
  endtask

  initial begin
    int ov0, cdc, n;
    bit saw;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ss", ss_n_o, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_cd", cycle_done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_sel", motor_sel, 0);
    chk("rst_tmask", timeout_mask, 0);
    chk("rst_count", sweep_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Full sweep
    motor_mask = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    start_sweep();
    chk("first_ss", ss_n_o, 4'b1110);
    wait_cd(400);
    enable = 1'b0;
    @(negedge clock);
    chk("full_count", sweep_count, 1);
    chk("full_cds", cd_count, 1);
    chk("full_queue", exp_q.size(), 0);

    // Sparse mask, with a mid-sweep mask change that must not take effect
    motor_mask = 4'b1010;
    exp_q.push_back(1); exp_q.push_back(3);
    start_sweep();
    motor_mask = 4'b0101;
    wait_cd(400);
    enable = 1'b0;
    @(negedge clock);
    chk("sparse_count", sweep_count, 2);
    chk("sparse_queue", exp_q.size(), 0);

    // Timeout on motor 2; the longer sweep also sees one tick while busy
    motor_mask = 4'b1111;
    withhold   = 4'b0100;
    ov0        = ov_count;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    start_sweep();
    n = 0;
    while (timeout_mask == 4'h0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_latency", cyc - start_cyc, TO + 1);
    chk("timeout_ss_high", ss_n_o, 4'hF);
    chk("timeout_mask", timeout_mask, 4'b0100);
    wait_cd(300);
    enable = 1'b0;
    @(negedge clock);
    chk("timeout_count", sweep_count, 3);
    chk("timeout_overrun", ov_count - ov0, 1);
    chk("timeout_queue", exp_q.size(), 0);
    pulse_err_clear();
    chk("err_clear", timeout_mask, 0);
    withhold = 4'b0000;

    // Overrun: every transfer times out, sweep spans two extra ticks
    withhold = 4'b1111;
    ov0      = ov_count;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    start_sweep();
    wait_cd(400);
    saw = 1'b0;
    repeat (30) begin
      @(negedge clock);
      saw |= busy;
    end
    enable = 1'b0;
    @(negedge clock);
    chk("no_queued_tick", saw, 0);
    chk("overrun_count", ov_count - ov0, 2);
    chk("all_timeouts", timeout_mask, 4'hF);
    chk("overrun_sweeps", sweep_count, 4);
    pulse_err_clear();
    chk("err_clear_all", timeout_mask, 0);
    withhold = 4'b0000;

    // Power loss during motor 1's transfer
    exp_q.push_back(0); exp_q.push_back(1);
    cdc = cd_count;
    start_sweep();
    wait_start(2'd1);
    power_sense_n = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("abort_idle", busy, 0);
    chk("abort_ss", ss_n_o, 4'hF);
    saw = 1'b0;
    repeat (110) begin
      @(negedge clock);
      saw |= busy;
    end
    enable = 1'b0;
    @(negedge clock);
    chk("no_sweep_unpowered", saw, 0);
    chk("abort_no_cd", cd_count, cdc);
    chk("abort_count", sweep_count, 4);
    chk("abort_queue", exp_q.size(), 0);
    power_sense_n = 1'b0;

    // Reset while waiting for completion
    exp_q.push_back(0);
    start_sweep();
    wait_start(2'd0);
    repeat (3) @(negedge clock);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    chk("midrst_ss", ss_n_o, 4'hF);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", sweep_count, 0);
    chk("midrst_sel", motor_sel, 0);
    reset = 1'b0;
    exp_q.delete();
    saw = 1'b0;
    repeat (20) begin
      @(negedge clock);
      saw |= busy | (ss_n_o != 4'hF) | cycle_done;
    end
    chk("late_done_ignored", saw, 0);

    // Sweep counter wrap
    @(negedge clock);
    force dut.sweep_count_q = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.sweep_count_q;
    @(negedge clock);
    chk("preload", sweep_count, 32'hFFFF_FFFF);
    motor_mask = 4'b0001;
    exp_q.push_back(0);
    start_sweep();
    wait_cd(200);
    enable = 1'b0;
    chk("wrap", sweep_count, 0);
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/myo_spi_scheduler.md
# myo_spi_scheduler

- Periodic round-robin sequencer for the SPI link between one myocontrol SPI master and its muscle control boards.
- Every update period it walks all enabled motors in ascending index order. For each one it asserts that motor's slave select, issues a start pulse to the SPI master and waits for completion.
- Stalled transfers are timed out and skipped. Sweeps are suppressed while motor power is absent.
- It sits between the Avalon-facing myocontrol register block and the SPI master, replacing software-driven slave-select sequencing.

## Interface
Parameters:
- NUM_MOTORS, 9: number of slave selects; range 1..16.
- PERIOD_CYCLES, 50000: clock cycles per update period (1 kHz at 50 MHz); ≥ 2.
- SS_LEAD, 4: cycles from ss_n low to spi_start; ≥ 1.
- SS_GAP, 8: idle cycles after ss_n high before the next motor's ss_n goes low; ≥ 1.
- TIMEOUT_CYCLES, 2048: maximum cycles in WAIT_DONE.

Ports:
- clock, in, 1: the block's only clock; already decided.
- reset, in, 1: synchronous, active-high; already decided.
- enable, in, 1: global run.
- motor_mask, in, NUM_MOTORS: per-motor enable; latched at sweep start.
- power_sense_n, in, 1: low means motor power is present.
- err_clear, in, 1: single-cycle pulse; clears timeout_mask.
- spi_done, in, 1: single-cycle pulse from the SPI master when its transfer completes.
- spi_start, out, 1: single-cycle pulse to the SPI master.
- motor_sel, out, $clog2(NUM_MOTORS) (min 1): index of the current motor.
- ss_n_o, out, NUM_MOTORS: active-low; at most one bit low at a time.
- busy, out, 1: high while a sweep is in progress.
- cycle_done, out, 1: pulse when a sweep completes.
- overrun, out, 1: pulse when a period tick occurs while busy.
- timeout_mask, out, NUM_MOTORS: sticky per-motor timeout flags.
- sweep_count, out, 32: count of completed sweeps; wraps.

## Operation
Period timer:
- Counts 0..PERIOD_CYCLES-1 while enable is high and is held at 0 while enable is low.
- tick is asserted when the count equals PERIOD_CYCLES-1.

States: IDLE, LEAD, START, WAIT_DONE, GAP.
- IDLE:
  - Sweep start condition: tick && enable && !power_sense_n && motor_mask != 0.
  - On the start condition: latch the mask, set idx to the lowest set bit, go to LEAD.
  - Otherwise the tick is dropped.
- LEAD:
  - ss_n_o[idx]=0 and motor_sel=idx.
  - Stays SS_LEAD cycles, then goes to START.
- START: spi_start=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE: exits on spi_done, or on timeout once the wait counter reaches TIMEOUT_CYCLES.
  - On timeout: set timeout_mask[idx] and treat the motor as finished.
  - On either exit: ss_n_o goes all-ones next cycle, then GAP.
- GAP: lasts SS_GAP cycles, then selects the next action.
  - Abort: if enable is low or power_sense_n is high, go to IDLE with no cycle_done and no sweep_count change.
  - Continue: else if the latched mask has a set bit above idx, set idx to it and go to LEAD.
  - Complete: else pulse cycle_done, increment sweep_count, go to IDLE.
- busy = (state != IDLE).

Other rules:
- A tick while busy pulses overrun. The tick is not queued and the sweep continues.
- motor_mask changes mid-sweep have no effect until the next sweep.
- An spi_done outside WAIT_DONE is ignored.
- A timeout and err_clear in the same cycle: the set wins for that bit; all other bits clear.

## Timing
Reset values (for one cycle after reset, and immediately on reset mid-sweep with no transfer completion):
- ss_n_o all-ones.
- spi_start, cycle_done, overrun, busy = 0.
- motor_sel = 0, timeout_mask = 0, sweep_count = 0.
- Timer = 0, state IDLE.

Cycle-level sequence, with the tick at cycle T:
- ss_n_o[first] low and busy high at T+1.
- spi_start high at T+1+SS_LEAD.
- spi_done at cycle D: ss_n_o high at D+1; next ss_n low at D+1+SS_GAP.
- cycle_done is asserted in the same cycle the last GAP expires.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package myo_sched_pkg holds:
  - the state enum (IDLE, LEAD, START, WAIT_DONE, GAP);
  - the index-width function clog2_min1;
  - MAX_MOTORS=16.
- Sub-module myo_sched_next_index: combinational find-first-set above a given index within the latched mask; outputs found and next_idx.
- The period timer, wait counters and FSM live in the top.

## Test plan
All scenarios use NUM_MOTORS=4, PERIOD_CYCLES=100, SS_LEAD=2, SS_GAP=3, TIMEOUT_CYCLES=50, and spi_done returned 10 cycles after spi_start.
- Full sweep: mask=4'b1111, power present → ss_n_o walks 1110, 1101, 1011, 0111 with spi_start 2 cycles after each select; one cycle_done; sweep_count=1.
- Sparse mask: mask=4'b1010 → only motors 1 and 3 are selected; motor_sel 1 then 3; no ss_n low on bits 0 and 2.
- Timeout: spi_done is withheld for motor 2 → timeout_mask=4'b0100 after 50 cycles, sweep continues to motor 3. A subsequent err_clear pulse → timeout_mask=0.
- Overrun and power loss:
  - PERIOD_CYCLES forced shorter than the sweep → overrun pulses once per extra tick; ticks are not queued.
  - power_sense_n raised during motor 1's transfer → motor 1 completes, then IDLE with no cycle_done.
- Reset mid-sweep: reset asserted during WAIT_DONE → next cycle ss_n_o=4'b1111, busy=0, sweep_count=0; a late spi_done is ignored.
- Wrap: sweep_count preloaded via force to 32'hFFFFFFFF → 0 after one more sweep.
